// File: rtl/data_step_sequencer.sv
// Table-driven stimulus sequencer: plays table[0..count_eff-1] on data_out,
// holding each entry for hold_eff cycles, then pulses done for one cycle.
module data_step_sequencer #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [HOLD_W-1:0] hold,
   input  logic [CNT_W-1:0]  count,
   input  logic              start,
   input  logic              abort,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] step_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [HOLD_W-1:0]   hold_q, hold_d, hcnt_q, hcnt_d, hold_eff;
   logic [CNT_W-1:0]    count_q, count_d, count_eff;
   logic [ADDR_W-1:0]   step_q, step_d, next_idx;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic                we, last_hold, last_step;

   assign hold_eff  = (hold == '0) ? HOLD_W'(1) : hold;
   assign count_eff = (count == '0 || count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;
   assign next_idx  = step_q + ADDR_W'(1);
   assign last_hold = (hcnt_q == hold_q - HOLD_W'(1));
   assign last_step = ({1'b0, step_q} == count_q - CNT_W'(1));

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      count_d = count_q;
      hcnt_d  = hcnt_q;
      step_d  = step_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      we      = 1'b0;
      case (state_q)
         IDLE: begin
            // start takes priority over a same-cycle table write
            if (start && !abort) begin
               state_d = PLAY;
               hold_d  = hold_eff;
               count_d = count_eff;
               hcnt_d  = '0;
               step_d  = '0;
               data_d  = mem_q[0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               we = wr_en;
            end
         end
         PLAY: begin
            if (abort) begin
               state_d = IDLE;
               hcnt_d  = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (!last_hold) begin
               hcnt_d = hcnt_q + HOLD_W'(1);
            end else if (!last_step) begin
               hcnt_d = '0;
               step_d = next_idx;
               data_d = mem_q[next_idx];
            end else begin
               state_d = DONE;
               hcnt_d  = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            we      = wr_en;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         count_q <= '0;
         hcnt_q  <= '0;
         step_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         count_q <= count_d;
         hcnt_q  <= hcnt_d;
         step_q  <= step_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign step_idx   = step_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
